nfc_cmd_queue: RTL and testbench



---
 rtl/nfc_cmd_queue_if.sv | 50 +++++
 rtl/nfc_cmd_queue.sv | 118 +++++++++++
 tb/tb_nfc_cmd_queue.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/nfc_cmd_queue_if.sv
// Command-queue port bundle: register-file push side, channel command side,
// and the status/control lines reported back to the register file.
interface nfc_cmd_queue_if #(
    parameter int DEPTH = 8,
    parameter int OPC_W = 16,
    parameter int LBA_W = 48,
    parameter int LEN_W = 24
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             wr_valid;
    logic [OPC_W-1:0] wr_opc;
    logic [LBA_W-1:0] wr_lba;
    logic [LEN_W-1:0] wr_len;
    logic             wr_ready;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [OPC_W-1:0] cmd_opc;
    logic [LBA_W-1:0] cmd_lba;
    logic [LEN_W-1:0] cmd_len;

    logic             flush;
    logic             clr_ovf;
    logic [CW-1:0]    q_count;
    logic             q_empty;
    logic             q_full;
    logic             ovf;
    logic [15:0]      issued_cnt;

    // Queue side
    modport slave (
        input  wr_valid, wr_opc, wr_lba, wr_len,
        output wr_ready,
        output cmd_valid, cmd_opc, cmd_lba, cmd_len,
        input  cmd_ready,
        input  flush, clr_ovf,
        output q_count, q_empty, q_full, ovf, issued_cnt
    );

    // Register-file / channel side
    modport master (
        output wr_valid, wr_opc, wr_lba, wr_len,
        input  wr_ready,
        input  cmd_valid, cmd_opc, cmd_lba, cmd_len,
        output cmd_ready,
        output flush, clr_ovf,
        input  q_count, q_empty, q_full, ovf, issued_cnt
    );
endinterface

// File: rtl/nfc_cmd_queue.sv
// In-order NAND command FIFO between the register file and the channel
// controller, with sticky overflow and a wrapping issued-command counter.
module nfc_cmd_queue #(
    parameter int DEPTH = 8,
    parameter int OPC_W = 16,
    parameter int LBA_W = 48,
    parameter int LEN_W = 24
) (
    input  logic                  s_axil_aclk,
    input  logic                  s_axil_aresetn,
    nfc_cmd_queue_if.slave        q_if
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = OPC_W + LBA_W + LEN_W;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("nfc_cmd_queue: DEPTH must be a power of 2 and at least 2");
        end
    endgenerate

    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   issued_q, issued_d;
    logic [EW-1:0] mem_q [DEPTH];

    logic          wr_ready;
    logic          cmd_valid;
    logic          push;
    logic          pop;
    logic          drop;
    logic          push_eff;
    logic          pop_eff;
    logic [EW-1:0] head;

    // Handshake readiness comes only from registered occupancy.
    assign wr_ready  = (cnt_q != CW'(DEPTH));
    assign cmd_valid = (cnt_q != '0);

    assign push     = q_if.wr_valid & wr_ready;
    assign pop      = cmd_valid & q_if.cmd_ready;
    assign drop     = q_if.wr_valid & ~wr_ready;
    assign push_eff = push & ~q_if.flush;
    assign pop_eff  = pop & ~q_if.flush;

    always_comb begin
        wp_d     = wp_q;
        rp_d     = rp_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        issued_d = issued_q;

        if (q_if.flush) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_eff) begin
                wp_d = wp_q + 1'b1;
            end
            if (pop_eff) begin
                rp_d     = rp_q + 1'b1;
                issued_d = issued_q + 16'd1;
            end
            if (push_eff && !pop_eff) begin
                cnt_d = cnt_q + 1'b1;
            end else if (pop_eff && !push_eff) begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        // A dropped push outranks a clear in the same cycle.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (q_if.clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
        if (!s_axil_aresetn) begin
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            issued_q <= '0;
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            issued_q <= issued_d;
        end
    end

    // Storage carries no reset; contents are only observed while cmd_valid=1.
    always_ff @(posedge s_axil_aclk) begin
        if (push_eff) begin
            mem_q[wp_q] <= {q_if.wr_opc, q_if.wr_lba, q_if.wr_len};
        end
    end

    assign head = mem_q[rp_q];

    assign q_if.wr_ready   = wr_ready;
    assign q_if.cmd_valid  = cmd_valid;
    assign q_if.cmd_opc    = head[EW-1 -: OPC_W];
    assign q_if.cmd_lba    = head[LBA_W+LEN_W-1 -: LBA_W];
    assign q_if.cmd_len    = head[LEN_W-1:0];
    assign q_if.q_count    = cnt_q;
    assign q_if.q_empty    = (cnt_q == '0);
    assign q_if.q_full     = (cnt_q == CW'(DEPTH));
    assign q_if.ovf        = ovf_q;
    assign q_if.issued_cnt = issued_q;
endmodule

// File: tb/tb_nfc_cmd_queue.sv
// Directed self-checking bench for nfc_cmd_queue.
module tb_nfc_cmd_queue;
    localparam int DEPTH = 8;
    localparam int OPC_W = 16;
    localparam int LBA_W = 48;
    localparam int LEN_W = 24;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    nfc_cmd_queue_if #(.DEPTH(DEPTH), .OPC_W(OPC_W), .LBA_W(LBA_W), .LEN_W(LEN_W)) q_if ();

    nfc_cmd_queue #(.DEPTH(DEPTH), .OPC_W(OPC_W), .LBA_W(LBA_W), .LEN_W(LEN_W)) dut (
        .s_axil_aclk    (clk),
        .s_axil_aresetn (rst_n),
        .q_if           (q_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [15:0] opc, input logic [47:0] lba, input logic [23:0] len);
        q_if.wr_valid = 1'b1;
        q_if.wr_opc   = opc;
        q_if.wr_lba   = lba;
        q_if.wr_len   = len;
        tick();
        q_if.wr_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n         = 1'b0;
        q_if.wr_valid  = 1'b0;
        q_if.wr_opc    = '0;
        q_if.wr_lba    = '0;
        q_if.wr_len    = '0;
        q_if.cmd_ready = 1'b0;
        q_if.flush     = 1'b0;
        q_if.clr_ovf   = 1'b0;

        // Reset values
        #12;
        chk("rst_cmd_valid", 64'(q_if.cmd_valid), 64'd0);
        chk("rst_wr_ready",  64'(q_if.wr_ready),  64'd1);
        chk("rst_q_empty",   64'(q_if.q_empty),   64'd1);
        chk("rst_q_full",    64'(q_if.q_full),    64'd0);
        chk("rst_q_count",   64'(q_if.q_count),   64'd0);
        chk("rst_ovf",       64'(q_if.ovf),       64'd0);
        chk("rst_issued",    64'(q_if.issued_cnt), 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic push then pop
        push_one(16'h00A5, 48'h1234_5678_9ABC, 24'h001000);
        chk("basic_valid", 64'(q_if.cmd_valid), 64'd1);
        chk("basic_opc",   64'(q_if.cmd_opc),   64'h00A5);
        chk("basic_lba",   64'(q_if.cmd_lba),   64'h1234_5678_9ABC);
        chk("basic_len",   64'(q_if.cmd_len),   64'h001000);
        chk("basic_count", 64'(q_if.q_count),   64'd1);
        q_if.cmd_ready = 1'b1;
        tick();
        q_if.cmd_ready = 1'b0;
        chk("basic_pop_valid", 64'(q_if.cmd_valid),  64'd0);
        chk("basic_issued",    64'(q_if.issued_cnt), 64'd1);

        // Fill to DEPTH, then one dropped push
        for (int i = 0; i < DEPTH; i++) push_one(16'h0100 + 16'(i), 48'(i), 24'(i));
        chk("fill_full",     64'(q_if.q_full),   64'd1);
        chk("fill_wr_ready", 64'(q_if.wr_ready), 64'd0);
        chk("fill_ovf_pre",  64'(q_if.ovf),      64'd0);
        push_one(16'h01FF, 48'hFF, 24'hFF);
        chk("ovf_set",   64'(q_if.ovf),     64'd1);
        chk("ovf_count", 64'(q_if.q_count), 64'd8);
        q_if.cmd_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_valid", 64'(q_if.cmd_valid), 64'd1);
            chk("drain_opc",   64'(q_if.cmd_opc),   64'h0100 + 64'(i));
            chk("drain_lba",   64'(q_if.cmd_lba),   64'(i));
            tick();
        end
        q_if.cmd_ready = 1'b0;
        chk("drain_empty",  64'(q_if.q_empty),    64'd1);
        chk("drain_issued", 64'(q_if.issued_cnt), 64'd9);
        q_if.clr_ovf = 1'b1;
        tick();
        q_if.clr_ovf = 1'b0;
        chk("ovf_clear", 64'(q_if.ovf), 64'd0);

        // Simultaneous push/pop at count 3
        for (int i = 0; i < 3; i++) push_one(16'h0200 + 16'(i), 48'd0, 24'd0);
        chk("sim3_count_pre", 64'(q_if.q_count), 64'd3);
        q_if.cmd_ready = 1'b1;
        push_one(16'h0203, 48'd0, 24'd0);
        chk("sim3_count", 64'(q_if.q_count), 64'd3);
        for (int i = 1; i < 4; i++) begin
            chk("sim3_order", 64'(q_if.cmd_opc), 64'h0200 + 64'(i));
            tick();
        end
        q_if.cmd_ready = 1'b0;
        chk("sim3_empty",  64'(q_if.q_empty),    64'd1);
        chk("sim3_issued", 64'(q_if.issued_cnt), 64'd13);

        // Simultaneous push/pop while full: push dropped
        for (int i = 0; i < DEPTH; i++) push_one(16'h0300 + 16'(i), 48'd0, 24'd0);
        q_if.cmd_ready = 1'b1;
        push_one(16'h03FF, 48'd0, 24'd0);
        chk("simfull_ovf",   64'(q_if.ovf),     64'd1);
        chk("simfull_count", 64'(q_if.q_count), 64'd7);
        for (int i = 1; i < DEPTH; i++) begin
            chk("simfull_order", 64'(q_if.cmd_opc), 64'h0300 + 64'(i));
            tick();
        end
        q_if.cmd_ready = 1'b0;
        chk("simfull_empty",  64'(q_if.q_empty),    64'd1);
        chk("simfull_issued", 64'(q_if.issued_cnt), 64'd21);
        q_if.clr_ovf = 1'b1;
        tick();
        q_if.clr_ovf = 1'b0;

        // Streaming wrap-around: push and pop every cycle, no empty bypass
        q_if.cmd_ready = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            q_if.wr_valid = (k < 20);
            q_if.wr_opc   = 16'(k);
            if (k >= 1) begin
                chk("wrap_valid", 64'(q_if.cmd_valid), 64'd1);
                chk("wrap_opc",   64'(q_if.cmd_opc),   64'(k - 1));
            end
            tick();
            if (k == 0) chk("wrap_no_bypass", 64'(q_if.q_count), 64'd1);
            if (k == 10) chk("wrap_steady", 64'(q_if.q_count), 64'd1);
        end
        q_if.wr_valid  = 1'b0;
        q_if.cmd_ready = 1'b0;
        chk("wrap_empty",  64'(q_if.q_empty),    64'd1);
        chk("wrap_issued", 64'(q_if.issued_cnt), 64'd41);

        // Flush with coincident push and pop
        for (int i = 0; i < 5; i++) push_one(16'h0500 + 16'(i), 48'd0, 24'd0);
        chk("flush_pre", 64'(q_if.q_count), 64'd5);
        q_if.flush     = 1'b1;
        q_if.cmd_ready = 1'b1;
        push_one(16'h05FF, 48'd0, 24'd0);
        q_if.flush     = 1'b0;
        q_if.cmd_ready = 1'b0;
        chk("flush_count",  64'(q_if.q_count),    64'd0);
        chk("flush_valid",  64'(q_if.cmd_valid),  64'd0);
        chk("flush_issued", 64'(q_if.issued_cnt), 64'd41);
        push_one(16'h0555, 48'h55, 24'h5);
        chk("flush_after_valid", 64'(q_if.cmd_valid), 64'd1);
        chk("flush_after_opc",   64'(q_if.cmd_opc),   64'h0555);
        chk("flush_after_count", 64'(q_if.q_count),   64'd1);
        q_if.cmd_ready = 1'b1;
        tick();
        q_if.cmd_ready = 1'b0;
        chk("flush_after_issued", 64'(q_if.issued_cnt), 64'd42);

        // Async reset mid-cycle with count 4, ovf set and a pop pending
        for (int i = 0; i <= DEPTH; i++) push_one(16'h0600 + 16'(i), 48'd0, 24'd0);
        q_if.cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("arst_pre_count", 64'(q_if.q_count), 64'd4);
        chk("arst_pre_ovf",   64'(q_if.ovf),     64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid",    64'(q_if.cmd_valid),  64'd0);
        chk("arst_count",    64'(q_if.q_count),    64'd0);
        chk("arst_issued",   64'(q_if.issued_cnt), 64'd0);
        chk("arst_ovf",      64'(q_if.ovf),        64'd0);
        chk("arst_wr_ready", 64'(q_if.wr_ready),   64'd1);
        chk("arst_empty",    64'(q_if.q_empty),    64'd1);
        q_if.cmd_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
